// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: 1101 preamble, payload MSB-first, even parity, then a zero gap.
// Feeds the serial line watched by the 1101 overlap detectors for frame sync.
module sync_frame_tx #(
    parameter int                 DATA_W  = 8,
    parameter int                 PRE_W   = 4,
    parameter logic [PRE_W-1:0]   PRE     = 4'b1101,
    parameter int                 GAP_LEN = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load,
    output logic              ready,
    output logic              out,
    output logic              busy,
    output logic              done
);

    localparam int MAX_LEN = (PRE_W > DATA_W) ? ((PRE_W > GAP_LEN) ? PRE_W : GAP_LEN)
                                              : ((DATA_W > GAP_LEN) ? DATA_W : GAP_LEN);
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_PAR,
        S_GAP
    } state_t;

    state_t              state, next_state;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic [DATA_W-1:0]   shift_reg, shift_next;
    logic [PRE_W-1:0]    pre_sr, pre_next;
    logic                parity, parity_next;
    logic                out_next, done_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // out is registered from the upcoming state, so each bit becomes visible the cycle after
    // the edge that selects it (the first preamble bit appears right after the accepting edge).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            shift_reg <= '0;
            pre_sr    <= '0;
            parity    <= 1'b0;
            out       <= 1'b0;
            done      <= 1'b0;
        end else begin
            cnt       <= cnt_next;
            shift_reg <= shift_next;
            pre_sr    <= pre_next;
            parity    <= parity_next;
            out       <= out_next;
            done      <= done_next;
        end
    end

    always_comb begin
        next_state  = state;
        cnt_next    = cnt;
        shift_next  = shift_reg;
        pre_next    = pre_sr;
        parity_next = parity;
        out_next    = 1'b0;
        done_next   = 1'b0;

        case (state)
            S_IDLE: begin
                if (load) begin
                    next_state  = S_PRE;
                    cnt_next    = '0;
                    shift_next  = data_in;
                    parity_next = ^data_in;
                    out_next    = PRE[PRE_W-1];
                    pre_next    = PRE << 1;
                end
            end

            S_PRE: begin
                if (cnt == CNT_W'(PRE_W - 1)) begin
                    next_state = S_DATA;
                    cnt_next   = '0;
                    out_next   = shift_reg[DATA_W-1];
                    shift_next = shift_reg << 1;
                end else begin
                    cnt_next   = cnt + CNT_W'(1);
                    out_next   = pre_sr[PRE_W-1];
                    pre_next   = pre_sr << 1;
                end
            end

            S_DATA: begin
                if (cnt == CNT_W'(DATA_W - 1)) begin
                    next_state = S_PAR;
                    cnt_next   = '0;
                    out_next   = parity;
                    done_next  = 1'b1;
                end else begin
                    cnt_next   = cnt + CNT_W'(1);
                    out_next   = shift_reg[DATA_W-1];
                    shift_next = shift_reg << 1;
                end
            end

            S_PAR: begin
                next_state = S_GAP;
                cnt_next   = '0;
            end

            S_GAP: begin
                if (cnt == CNT_W'(GAP_LEN - 1)) begin
                    next_state = S_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt + CNT_W'(1);
                end
            end

            default: begin
                next_state = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign ready = (state == S_IDLE);
    assign busy  = ~ready;

endmodule
